// File: rtl/rr_arbiter8_enc.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// Produces a registered one-hot grant, its encoded index, a valid flag and a preemption pulse.
module rr_arbiter8_enc #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNTW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_vld,
    output logic       timeout
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDXW = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

    logic [0:0]      state_q,   state_d;
    logic [IDXW-1:0] ptr_q,     ptr_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [IDXW-1:0] idx_q,     idx_d;
    logic            vld_q,     vld_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] next_ptr_c;
    logic [IDXW-1:0] win_ptr_c;
    logic [IDXW-1:0] win_next_c;
    logic [NREQ-1:0] others_c;

    // First set bit of r at or after start, wrapping 7->0; r must be non-zero.
    function automatic logic [IDXW-1:0] find_winner(input logic [NREQ-1:0] r,
                                                    input logic [IDXW-1:0] start);
        logic [IDXW-1:0] w;
        logic [IDXW-1:0] j;
        logic            found;
        w     = start;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = start + IDXW'(i);
            if (!found && r[j]) begin
                w     = j;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign next_ptr_c = idx_q + IDXW'(1);
    assign win_ptr_c  = find_winner(req, ptr_q);
    assign win_next_c = find_winner(req, next_ptr_c);
    assign others_c   = req & ~(NREQ'(1) << idx_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    idx_d      = win_ptr_c;
                    grant_d    = NREQ'(1) << win_ptr_c;
                    vld_d      = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[idx_q]) begin
                    // Holder released: rotate priority past it.
                    ptr_d      = next_ptr_c;
                    hold_cnt_d = '0;
                    if (req != '0) begin
                        idx_d   = win_next_c;
                        grant_d = NREQ'(1) << win_next_c;
                    end else begin
                        idx_d   = '0;
                        grant_d = '0;
                        vld_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end else if (others_c != '0) begin
                    // Hold budget spent with others waiting: preempt.
                    timeout_d  = 1'b1;
                    ptr_d      = next_ptr_c;
                    idx_d      = win_next_c;
                    grant_d    = NREQ'(1) << win_next_c;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                grant_d = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign grant_vld = vld_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Bench for rr_arbiter8_enc: directed scenarios plus random traffic against a
// holder/ptr/held-cycles reference model.
module tb_rr_arbiter8_enc;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       timeout;

    int vectors;
    int miscompares;

    // Reference model state: current holder (-1 none), cycles it has held, priority start.
    int   m_ptr;
    int   m_holder;
    int   m_held;
    logic m_to;

    rr_arbiter8_enc #(.MAX_HOLD(MAX_HOLD), .CNTW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [7:0] r);
        m_to = 1'b0;
        if (r_rst) begin
            m_ptr = 0; m_holder = -1; m_held = 0;
        end else if (m_holder < 0) begin
            if (r != 8'h00) begin
                m_holder = search(r, m_ptr); m_held = 1;
            end
        end else if (!r[m_holder]) begin
            m_ptr = (m_holder + 1) % 8;
            m_holder = search(r, m_ptr);
            m_held = (m_holder < 0) ? 0 : 1;
        end else if (m_held < MAX_HOLD) begin
            m_held++;
        end else if ((r & ~(8'h01 << m_holder)) != 8'h00) begin
            m_to = 1'b1;
            m_ptr = (m_holder + 1) % 8;
            m_holder = search(r, m_ptr);
            m_held = 1;
        end else begin
            m_held = 1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] eg;
        eg = (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
        chk("grant", int'(grant), int'(eg));
        chk("grant_idx", int'(grant_idx), (m_holder < 0) ? 0 : m_holder);
        chk("grant_vld", int'(grant_vld), (m_holder < 0) ? 0 : 1);
        chk("timeout", int'(timeout), int'(m_to));
    endtask

    task automatic step(input logic s_rst, input logic [7:0] s_req);
        rst = s_rst;
        req = s_req;
        @(posedge clk);
        model_edge(s_rst, s_req);
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] r;
        vectors = 0;
        miscompares = 0;
        m_ptr = 0; m_holder = -1; m_held = 0; m_to = 1'b0;
        rst = 1'b1;
        req = 8'hFF;

        // Reset with every requester active.
        step(1'b1, 8'hFF);
        step(1'b1, 8'hFF);
        chk("reset_vld", int'(grant_vld), 0);

        // Single request, then drop.
        step(1'b0, 8'b0000_0100);
        chk("single_idx", int'(grant_idx), 2);
        step(1'b0, 8'h00);
        chk("single_drop_vld", int'(grant_vld), 0);

        // Fair rotation: holder drops its bit for one edge, everyone else keeps requesting.
        step(1'b1, 8'h00);
        step(1'b0, 8'hFF);
        chk("rot_first", int'(grant_idx), 0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'hFF & ~(8'h01 << grant_idx));
            chk("rot_seq", int'(grant_idx), k % 8);
            chk("rot_vld", int'(grant_vld), 1);
        end

        // Wrap-around: release requester 5 so ptr sits at 6.
        step(1'b1, 8'h00);
        step(1'b0, 8'b0010_0000);
        chk("wrap_5", int'(grant_idx), 5);
        step(1'b0, 8'h00);
        step(1'b0, 8'b0000_0011);
        chk("wrap_0", int'(grant_idx), 0);
        step(1'b0, 8'b0000_0010);
        chk("wrap_1", int'(grant_idx), 1);

        // Preemption with two constant requesters.
        step(1'b1, 8'h00);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 8'b0000_0011);
            chk("pre_idx", int'(grant_idx), (k / 16) % 2);
            chk("pre_to", int'(timeout), (k == 16 || k == 32) ? 1 : 0);
        end

        // Lone holder is never preempted.
        step(1'b1, 8'h00);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 8'b1000_0000);
            chk("lone_vld", int'(grant_vld), 1);
            chk("lone_to", int'(timeout), 0);
        end

        // Reset mid-hold of requester 3, then ptr must be back at 0.
        step(1'b1, 8'h00);
        for (int k = 0; k < 8; k++) step(1'b0, 8'b0000_1000);
        chk("mid_idx", int'(grant_idx), 3);
        step(1'b1, 8'b0000_1000);
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_vld", int'(grant_vld), 0);
        step(1'b0, 8'hFF);
        chk("mid_after_idx", int'(grant_idx), 0);

        // Random traffic: requests mostly persist, occasional reset.
        r = 8'h00;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0 && grant_vld) r = r & ~grant;
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
